orv64_pc_breakpoint_unit: RTL and testbench

Parametrised hardware breakpoint unit for the orv64 core, sitting beside the pipeline and driven by debug CSRs. It compares registered IF-stage and WB-stage PCs against N_IF and N_WB programmable address/mask slots and an instret target. Each slot has a hit-skip counter. Any firing source stops the pipeline and holds it in a halted state until debug resume, capturing the cause and the hit PC.

---
 rtl/orv64_pc_breakpoint_unit_if.sv | 55 +++++
 rtl/orv64_pc_breakpoint_unit.sv | 143 ++++++++++++++
 tb/tb_orv64_pc_breakpoint_unit.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/orv64_pc_breakpoint_unit_if.sv
// Signal bundle between the orv64 pipeline / debug CSRs and the PC breakpoint unit.
//
// Handshake semantics: if_valid / wb_valid qualify if_pc / wb_pc in the same
// cycle. There is no ready; the unit never back-pressures a PC. It answers with
// bp_stall, which the pipeline must obey in the same cycle. resume and clr_cnt
// are single-cycle pulses. All configuration inputs are level signals that are
// sampled every cycle.
interface orv64_pc_breakpoint_unit_if #(
  parameter int N_IF    = 4,
  parameter int N_WB    = 4,
  parameter int VADDR_W = 39,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) ();
  // debug CSR configuration
  logic [N_IF-1:0]            bp_if_en;
  logic [N_IF*VADDR_W-1:0]    bp_if_addr;
  logic [N_IF*VADDR_W-1:0]    bp_if_mask;
  logic [N_IF*CNT_W-1:0]      bp_if_skip;
  logic [N_WB-1:0]            bp_wb_en;
  logic [N_WB*VADDR_W-1:0]    bp_wb_addr;
  logic [N_WB*VADDR_W-1:0]    bp_wb_mask;
  logic [N_WB*CNT_W-1:0]      bp_wb_skip;
  logic                       instret_bp_en;
  logic [DATA_W-1:0]          instret_bp;
  logic                       clr_cnt;
  logic                       resume;
  // pipeline observation
  logic [VADDR_W-1:0]         if_pc;
  logic [VADDR_W-1:0]         wb_pc;
  logic                       if_valid;
  logic                       wb_valid;
  logic [DATA_W-1:0]          minstret;
  // breakpoint results
  logic                       bp_stall;
  logic                       bp_halted;
  logic [N_IF+N_WB:0]         bp_cause;
  logic [VADDR_W-1:0]         bp_hit_pc;

  modport master (
    output bp_if_en, bp_if_addr, bp_if_mask, bp_if_skip,
    output bp_wb_en, bp_wb_addr, bp_wb_mask, bp_wb_skip,
    output instret_bp_en, instret_bp, clr_cnt, resume,
    output if_pc, wb_pc, if_valid, wb_valid, minstret,
    input  bp_stall, bp_halted, bp_cause, bp_hit_pc
  );

  modport slave (
    input  bp_if_en, bp_if_addr, bp_if_mask, bp_if_skip,
    input  bp_wb_en, bp_wb_addr, bp_wb_mask, bp_wb_skip,
    input  instret_bp_en, instret_bp, clr_cnt, resume,
    input  if_pc, wb_pc, if_valid, wb_valid, minstret,
    output bp_stall, bp_halted, bp_cause, bp_hit_pc
  );
endinterface

// File: rtl/orv64_pc_breakpoint_unit.sv
// orv64 hardware PC breakpoint unit: N_IF IF-stage slots, N_WB WB-stage slots
// and one instret target, each slot with a hit-skip counter. Any firing source
// stalls the pipeline and parks it in HALT until a debug resume. bp_halted is
// the FSM state bit, so the state is directly observable.
module orv64_pc_breakpoint_unit #(
  parameter int N_IF    = 4,
  parameter int N_WB    = 4,
  parameter int VADDR_W = 39,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  orv64_pc_breakpoint_unit_if.slave bp
);

  localparam int CAUSE_W = N_IF + N_WB + 1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 run;

  logic                 v_if;
  logic                 v_wb;
  logic [VADDR_W-1:0]   pc_if;
  logic [VADDR_W-1:0]   pc_wb;
  logic                 instret_m;

  logic [CNT_W-1:0]     cnt_if [N_IF];
  logic [CNT_W-1:0]     cnt_wb [N_WB];

  logic [N_IF-1:0]      m_if;
  logic [N_IF-1:0]      fire_if;
  logic [N_WB-1:0]      m_wb;
  logic [N_WB-1:0]      fire_wb;
  logic                 fire;

  logic [CAUSE_W-1:0]   cause_q;
  logic [VADDR_W-1:0]   hit_pc_q;

  assign run = (state_q == S_RUN);

  // Register stage valids every cycle; PCs load only when they can matter
  // (valid and at least one slot of that stage armed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_if      <= 1'b0;
      v_wb      <= 1'b0;
      pc_if     <= '0;
      pc_wb     <= '0;
      instret_m <= 1'b0;
    end else begin
      v_if      <= bp.if_valid;
      v_wb      <= bp.wb_valid;
      instret_m <= bp.instret_bp_en && (bp.minstret == bp.instret_bp);
      if (bp.if_valid && (|bp.bp_if_en)) begin
        pc_if <= bp.if_pc;
      end
      if (bp.wb_valid && (|bp.bp_wb_en)) begin
        pc_wb <= bp.wb_pc;
      end
    end
  end

  // Masked address compare per slot; a slot fires when it matches in RUN and
  // its skip counter has reached the programmed skip value.
  always_comb begin
    m_if    = '0;
    fire_if = '0;
    m_wb    = '0;
    fire_wb = '0;
    for (int i = 0; i < N_IF; i++) begin
      m_if[i]    = v_if && bp.bp_if_en[i] &&
                   (((pc_if ^ bp.bp_if_addr[i*VADDR_W +: VADDR_W]) &
                     ~bp.bp_if_mask[i*VADDR_W +: VADDR_W]) == '0);
      fire_if[i] = run && m_if[i] && (cnt_if[i] == bp.bp_if_skip[i*CNT_W +: CNT_W]);
    end
    for (int i = 0; i < N_WB; i++) begin
      m_wb[i]    = v_wb && bp.bp_wb_en[i] &&
                   (((pc_wb ^ bp.bp_wb_addr[i*VADDR_W +: VADDR_W]) &
                     ~bp.bp_wb_mask[i*VADDR_W +: VADDR_W]) == '0);
      fire_wb[i] = run && m_wb[i] && (cnt_wb[i] == bp.bp_wb_skip[i*CNT_W +: CNT_W]);
    end
    fire = (|fire_if) || (|fire_wb) || (run && instret_m);
  end

  // Skip counters: count matches in RUN, clear on fire; clr_cnt wins over
  // everything. Frozen in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IF; i++) cnt_if[i] <= '0;
      for (int i = 0; i < N_WB; i++) cnt_wb[i] <= '0;
    end else if (bp.clr_cnt) begin
      for (int i = 0; i < N_IF; i++) cnt_if[i] <= '0;
      for (int i = 0; i < N_WB; i++) cnt_wb[i] <= '0;
    end else if (run) begin
      for (int i = 0; i < N_IF; i++) begin
        if (m_if[i]) cnt_if[i] <= fire_if[i] ? '0 : cnt_if[i] + CNT_W'(1);
      end
      for (int i = 0; i < N_WB; i++) begin
        if (m_wb[i]) cnt_wb[i] <= fire_wb[i] ? '0 : cnt_wb[i] + CNT_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: any fire halts, only resume leaves HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (fire)      state_d = S_HALT;
      S_HALT:  if (bp.resume) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Capture cause and hit PC on the RUN->HALT transition; they survive resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q  <= '0;
      hit_pc_q <= '0;
    end else if (run && fire) begin
      cause_q  <= {instret_m, fire_wb, fire_if};
      hit_pc_q <= (|fire_if) ? pc_if : pc_wb;
    end
  end

  assign bp.bp_stall  = (run && fire) || (state_q == S_HALT);
  assign bp.bp_halted = (state_q == S_HALT);
  assign bp.bp_cause  = cause_q;
  assign bp.bp_hit_pc = hit_pc_q;

endmodule

// File: tb/tb_orv64_pc_breakpoint_unit.sv
// Bench for orv64_pc_breakpoint_unit: directed scenarios plus randomized
// transactions, with expected halt records queued by the driver and checked
// by an independent monitor on every bp_halted rising edge.
module tb_orv64_pc_breakpoint_unit;
  localparam int N_IF    = 4;
  localparam int N_WB    = 4;
  localparam int VADDR_W = 39;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 16;
  localparam int CW      = N_IF + N_WB + 1;
  localparam int EW      = CW + VADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  orv64_pc_breakpoint_unit_if #(
    .N_IF(N_IF), .N_WB(N_WB), .VADDR_W(VADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) bus ();

  orv64_pc_breakpoint_unit #(
    .N_IF(N_IF), .N_WB(N_WB), .VADDR_W(VADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bus)
  );

  // ---------------- configuration ----------------
  logic [N_IF-1:0]    cfg_if_en;
  logic [VADDR_W-1:0] cfg_if_addr [N_IF];
  logic [VADDR_W-1:0] cfg_if_mask [N_IF];
  logic [CNT_W-1:0]   cfg_if_skip [N_IF];
  logic [N_WB-1:0]    cfg_wb_en;
  logic [VADDR_W-1:0] cfg_wb_addr [N_WB];
  logic [VADDR_W-1:0] cfg_wb_mask [N_WB];
  logic [CNT_W-1:0]   cfg_wb_skip [N_WB];

  always_comb begin
    bus.bp_if_en   = cfg_if_en;
    bus.bp_wb_en   = cfg_wb_en;
    bus.bp_if_addr = '0;
    bus.bp_if_mask = '0;
    bus.bp_if_skip = '0;
    bus.bp_wb_addr = '0;
    bus.bp_wb_mask = '0;
    bus.bp_wb_skip = '0;
    for (int i = 0; i < N_IF; i++) begin
      bus.bp_if_addr[i*VADDR_W +: VADDR_W] = cfg_if_addr[i];
      bus.bp_if_mask[i*VADDR_W +: VADDR_W] = cfg_if_mask[i];
      bus.bp_if_skip[i*CNT_W +: CNT_W]     = cfg_if_skip[i];
    end
    for (int i = 0; i < N_WB; i++) begin
      bus.bp_wb_addr[i*VADDR_W +: VADDR_W] = cfg_wb_addr[i];
      bus.bp_wb_mask[i*VADDR_W +: VADDR_W] = cfg_wb_mask[i];
      bus.bp_wb_skip[i*CNT_W +: CNT_W]     = cfg_wb_skip[i];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q [$];

  // Matches seen per slot since its last fire or clear.
  int seen_if [N_IF];
  int seen_wb [N_WB];
  logic [VADDR_W-1:0] last_wb_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_IF; i++) seen_if[i] = 0;
    for (int i = 0; i < N_WB; i++) seen_wb[i] = 0;
  endtask

  // A slot with skip S fires on every (S+1)-th match it sees in RUN.
  task automatic model_txn(input logic ifv, input logic [VADDR_W-1:0] ipc,
                           input logic wbv, input logic [VADDR_W-1:0] wpc,
                           output logic [CW-1:0] c, output logic [VADDR_W-1:0] hp);
    c = '0;
    if (wbv && (cfg_wb_en != '0)) last_wb_pc = wpc;
    for (int i = 0; i < N_IF; i++) begin
      if (ifv && cfg_if_en[i] && (((ipc ^ cfg_if_addr[i]) & ~cfg_if_mask[i]) == '0)) begin
        if (seen_if[i] == int'(cfg_if_skip[i])) begin
          c[i] = 1'b1;
          seen_if[i] = 0;
        end else begin
          seen_if[i] = seen_if[i] + 1;
        end
      end
    end
    for (int i = 0; i < N_WB; i++) begin
      if (wbv && cfg_wb_en[i] && (((wpc ^ cfg_wb_addr[i]) & ~cfg_wb_mask[i]) == '0)) begin
        if (seen_wb[i] == int'(cfg_wb_skip[i])) begin
          c[N_IF+i] = 1'b1;
          seen_wb[i] = 0;
        end else begin
          seen_wb[i] = seen_wb[i] + 1;
        end
      end
    end
    hp = (c[N_IF-1:0] != '0) ? ipc : last_wb_pc;
  endtask

  // ---------------- monitor ----------------
  logic mon_prev = 1'b0;
  logic [EW-1:0] mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.bp_halted === 1'b1 && mon_prev === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_halt: cause 0x%0h pc 0x%0h with no halt expected at %0t",
                   bus.bp_cause, bus.bp_hit_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("halt_cause", 64'(bus.bp_cause), 64'(mon_e[EW-1:VADDR_W]));
          check("halt_pc", 64'(bus.bp_hit_pc), 64'(mon_e[VADDR_W-1:0]));
        end
      end
      mon_prev = bus.bp_halted;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic resume_pulse();
    @(negedge clk);
    bus.resume = 1'b1;
    @(negedge clk);
    bus.resume = 1'b0;
    check("resume_halted", 64'(bus.bp_halted), 64'd0);
    check("resume_stall", 64'(bus.bp_stall), 64'd0);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    model_clear();
  endtask

  // One-cycle PC presentation. If it fires, optionally poke a PC while halted
  // (must not be counted), then optionally resume.
  task automatic txn(input logic ifv, input logic [VADDR_W-1:0] ipc,
                     input logic wbv, input logic [VADDR_W-1:0] wpc,
                     input logic poke, input logic [VADDR_W-1:0] poke_pc,
                     input logic do_resume);
    logic [CW-1:0] c;
    logic [VADDR_W-1:0] hp;
    model_txn(ifv, ipc, wbv, wpc, c, hp);
    if (c != '0) exp_q.push_back({c, hp});
    @(negedge clk);
    bus.if_valid = ifv;
    bus.if_pc    = ipc;
    bus.wb_valid = wbv;
    bus.wb_pc    = wpc;
    @(negedge clk);
    bus.if_valid = 1'b0;
    bus.wb_valid = 1'b0;
    check("stall_t1", 64'(bus.bp_stall), 64'(c != '0));
    @(negedge clk);
    check("halted_t2", 64'(bus.bp_halted), 64'(c != '0));
    if (c != '0) begin
      if (poke) begin
        bus.if_valid = 1'b1;
        bus.if_pc    = poke_pc;
        @(negedge clk);
        bus.if_valid = 1'b0;
        @(negedge clk);
        check("cause_hold", 64'(bus.bp_cause), 64'(c));
        check("pc_hold", 64'(bus.bp_hit_pc), 64'(hp));
        check("stall_in_halt", 64'(bus.bp_stall), 64'd1);
      end
      if (do_resume) resume_pulse();
    end
  endtask

  // ---------------- main sequence ----------------
  logic [CW-1:0] ic;
  initial begin
    rst_n = 1'b0;
    cfg_if_en = '0;
    cfg_wb_en = '0;
    for (int i = 0; i < N_IF; i++) begin
      cfg_if_addr[i] = '0; cfg_if_mask[i] = '0; cfg_if_skip[i] = '0;
    end
    for (int i = 0; i < N_WB; i++) begin
      cfg_wb_addr[i] = '0; cfg_wb_mask[i] = '0; cfg_wb_skip[i] = '0;
    end
    bus.instret_bp_en = 1'b0;
    bus.instret_bp    = '0;
    bus.clr_cnt       = 1'b0;
    bus.resume        = 1'b0;
    bus.if_pc         = '0;
    bus.wb_pc         = '0;
    bus.if_valid      = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.minstret      = '0;
    model_clear();
    last_wb_pc = '0;

    repeat (3) @(negedge clk);
    check("rst_stall", 64'(bus.bp_stall), 64'd0);
    check("rst_halted", 64'(bus.bp_halted), 64'd0);
    check("rst_cause", 64'(bus.bp_cause), 64'd0);
    check("rst_pc", 64'(bus.bp_hit_pc), 64'd0);
    rst_n = 1'b1;

    // IF slot0 exact match, skip 0
    cfg_if_en[0] = 1'b1;
    cfg_if_addr[0] = 39'h80000100;
    txn(1'b1, 39'h80000100, 1'b0, '0, 1'b0, '0, 1'b1);

    // WB slot2 with low byte masked
    cfg_wb_en[2] = 1'b1;
    cfg_wb_addr[2] = 39'h80000000;
    cfg_wb_mask[2] = 39'hFF;
    txn(1'b0, '0, 1'b1, 39'h800000A4, 1'b0, '0, 1'b1);
    txn(1'b0, '0, 1'b1, 39'h80000104, 1'b0, '0, 1'b1);

    // IF slot1 skip 3: fires on every 4th match; clr_cnt restarts the count
    cfg_if_en[1] = 1'b1;
    cfg_if_addr[1] = 39'h80000200;
    cfg_if_skip[1] = 16'd3;
    for (int k = 0; k < 8; k++) txn(1'b1, 39'h80000200, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 2; k++) txn(1'b1, 39'h80000200, 1'b0, '0, 1'b0, '0, 1'b1);
    clr_pulse();
    for (int k = 0; k < 4; k++) txn(1'b1, 39'h80000200, 1'b0, '0, 1'b0, '0, 1'b1);

    // instret breakpoint: one stall starting the cycle after minstret == 1000
    bus.instret_bp    = 64'd1000;
    bus.instret_bp_en = 1'b1;
    ic = '0;
    ic[CW-1] = 1'b1;
    exp_q.push_back({ic, last_wb_pc});
    for (int v = 998; v <= 1002; v++) begin
      @(negedge clk);
      bus.minstret = 64'(v);
      if (v >= 999) check("instret_stall", 64'(bus.bp_stall), 64'((v - 1) >= 1000));
    end
    @(negedge clk);
    bus.minstret = '0;
    check("instret_halted", 64'(bus.bp_halted), 64'd1);
    resume_pulse();
    bus.instret_bp_en = 1'b0;
    for (int v = 998; v <= 1002; v++) begin
      @(negedge clk);
      bus.minstret = 64'(v);
      check("instret_off", 64'(bus.bp_stall), 64'd0);
    end
    @(negedge clk);
    bus.minstret = '0;

    // Simultaneous IF slot0 / WB slot0 fire; slot1 poked while halted
    cfg_wb_en[0] = 1'b1;
    cfg_wb_addr[0] = 39'h80001000;
    txn(1'b1, 39'h80000100, 1'b1, 39'h80001000, 1'b1, 39'h80000200, 1'b1);
    for (int k = 0; k < 4; k++) txn(1'b1, 39'h80000200, 1'b0, '0, 1'b0, '0, 1'b1);

    // Reset while halted with slot1 counter at 2
    for (int k = 0; k < 2; k++) txn(1'b1, 39'h80000200, 1'b0, '0, 1'b0, '0, 1'b1);
    txn(1'b1, 39'h80000100, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_stall", 64'(bus.bp_stall), 64'd0);
    check("arst_halted", 64'(bus.bp_halted), 64'd0);
    check("arst_cause", 64'(bus.bp_cause), 64'd0);
    check("arst_pc", 64'(bus.bp_hit_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    last_wb_pc = '0;
    for (int k = 0; k < 4; k++) txn(1'b1, 39'h80000200, 1'b0, '0, 1'b0, '0, 1'b1);

    // Randomized phase
    for (int r = 0; r < 4; r++) begin
      int m_if_sel;
      for (int i = 0; i < N_IF; i++) begin
        cfg_if_en[i]   = 1'($urandom_range(0, 1));
        cfg_if_addr[i] = 39'h80000000 + VADDR_W'(i * 256);
        m_if_sel       = int'($urandom_range(0, 2));
        cfg_if_mask[i] = (m_if_sel == 0) ? 39'h0 : (m_if_sel == 1) ? 39'h3 : 39'hF;
        cfg_if_skip[i] = CNT_W'($urandom_range(0, 2));
      end
      for (int i = 0; i < N_WB; i++) begin
        cfg_wb_en[i]   = 1'($urandom_range(0, 1));
        cfg_wb_addr[i] = 39'h80001000 + VADDR_W'(i * 256);
        m_if_sel       = int'($urandom_range(0, 2));
        cfg_wb_mask[i] = (m_if_sel == 0) ? 39'h0 : (m_if_sel == 1) ? 39'h3 : 39'hF;
        cfg_wb_skip[i] = CNT_W'($urandom_range(0, 2));
      end
      for (int t = 0; t < 25; t++) begin
        logic [VADDR_W-1:0] ipc, wpc;
        ipc = 39'h80000000 + VADDR_W'($urandom_range(0, N_IF - 1) * 256 + $urandom_range(0, 20));
        wpc = 39'h80001000 + VADDR_W'($urandom_range(0, N_WB - 1) * 256 + $urandom_range(0, 20));
        if ($urandom_range(0, 9) == 0) clr_pulse();
        txn(1'($urandom_range(0, 1)), ipc, 1'($urandom_range(0, 1)), wpc,
            1'($urandom_range(0, 1)), ipc, 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
